// File: rtl/fifo_sram_showahead_lvl.sv
// rtl/fifo_sram_showahead_lvl.sv - show-ahead FIFO on a 1R1W SRAM with level, almost flags, flush and sticky errors
//
// fifo_sram_showahead_lvl: first-word-fall-through FIFO. SRAM read latency is
// hidden by a bypass/prefetch output register.
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   flush_i                           synchronous clear of contents (beats push/pop)
//   wr_valid_i, wr_ready_o, wr_data_i write side handshake and data
//   rd_valid_o, rd_ready_i, rd_data_o read side handshake and head word
//   level_o                           occupancy 0..DEPTH
//   almost_full_o, almost_empty_o     level_o >= AF_LEVEL, level_o <= AE_LEVEL
//   overflow_o, underflow_o           sticky error flags, cleared by err_clr_i
//
// sram_dualport: one-write-one-read synchronous SRAM, registered read data
// that holds its value while ren is low.
//   clk_i, wen, waddr, wdata          write port
//   ren, raddr, rdata                 read port

module sram_dualport #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
        if (ren) begin
            rdata <= mem[raddr];
        end
    end
endmodule

module fifo_sram_showahead_lvl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    input  logic                       err_clr_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             byp_valid_q;
    logic [WIDTH-1:0] byp_data_q;
    logic             ovf_q;
    logic             unf_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             sram_wen;
    logic             sram_ren;
    logic [WIDTH-1:0] sram_rdata;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign push   = wr_valid_i & ~full;
    assign pop    = rd_ready_i & ~empty;

    // The new word becomes the head directly when nothing else will be ahead
    // of it after this edge: FIFO empty, or the only word is leaving now.
    assign bypass = push & (empty | ((level_q == LW'(1)) & pop));

    // Every non-head word lives in SRAM at its slot; a pop with a second word
    // present prefetches that word (slot rd_ptr+1) into the SRAM read register.
    // wr_ptr = rd_ptr + level, so with level >= 2 the read slot never equals
    // the write slot.
    assign sram_wen = push & ~bypass & ~flush_i;
    assign sram_ren = pop & (level_q >= LW'(2)) & ~flush_i;

    sram_dualport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_sram (
        .clk_i (clk_i),
        .wen   (sram_wen),
        .waddr (wr_ptr_q),
        .wdata (wr_data_i),
        .ren   (sram_ren),
        .raddr (wrap_inc(rd_ptr_q)),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            byp_valid_q <= 1'b0;
            byp_data_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            byp_valid_q <= 1'b0;
        end else begin
            // Pointers advance for bypassed words too, keeping slot order intact.
            if (push) begin
                wr_ptr_q <= wrap_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
            if (bypass) begin
                byp_valid_q <= 1'b1;
                byp_data_q  <= wr_data_i;
            end else if (pop) begin
                byp_valid_q <= 1'b0;
            end
        end
    end

    // Set beats clear; flush leaves the error history alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (wr_valid_i & full) | (ovf_q & ~err_clr_i);
            unf_q <= (rd_ready_i & empty) | (unf_q & ~err_clr_i);
        end
    end

    assign wr_ready_o     = ~full;
    assign rd_valid_o     = ~empty;
    assign rd_data_o      = byp_valid_q ? byp_data_q : sram_rdata;
    assign level_o        = level_q;
    assign almost_full_o  = (level_q >= LW'(AF_LEVEL));
    assign almost_empty_o = (level_q <= LW'(AE_LEVEL));
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
endmodule

// File: tb/tb_fifo_sram_showahead_lvl.sv
// tb/tb_fifo_sram_showahead_lvl.sv - self-checking bench for fifo_sram_showahead_lvl (WIDTH=8, DEPTH=5)

module tb_fifo_sram_showahead_lvl;
    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = D - 1;
    localparam int AE = 1;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         flush_i = 1'b0;
    logic         wr_valid_i = 1'b0;
    logic         wr_ready_o;
    logic [W-1:0] wr_data_i = '0;
    logic         rd_valid_o;
    logic         rd_ready_i = 1'b0;
    logic [W-1:0] rd_data_o;
    logic [2:0]   level_o;
    logic         almost_full_o;
    logic         almost_empty_o;
    logic         overflow_o;
    logic         underflow_o;
    logic         err_clr_i = 1'b0;

    int total = 0;
    int bad   = 0;

    fifo_sram_showahead_lvl #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .wr_data_i      (wr_data_i),
        .rd_valid_o     (rd_valid_o),
        .rd_ready_i     (rd_ready_i),
        .rd_data_o      (rd_data_o),
        .level_o        (level_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .err_clr_i      (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words plus two flags.
    logic [W-1:0] mq[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    int   m_n;

    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_n = mq.size();
            m_ovf = (wr_valid_i && m_n == D) || (m_ovf && !err_clr_i);
            m_unf = (rd_ready_i && m_n == 0) || (m_unf && !err_clr_i);
            if (flush_i) begin
                mq.delete();
            end else begin
                if (rd_ready_i && m_n > 0) void'(mq.pop_front());
                if (wr_valid_i && m_n < D) mq.push_back(wr_data_i);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic chk_en = 1'b0;
    initial forever begin
        @(negedge clk_i);
        if (chk_en) begin
            chk("m_level", 32'(level_o), 32'(mq.size()));
            chk("m_rd_valid", 32'(rd_valid_o), 32'(mq.size() != 0));
            chk("m_wr_ready", 32'(wr_ready_o), 32'(mq.size() != D));
            chk("m_af", 32'(almost_full_o), 32'(mq.size() >= AF));
            chk("m_ae", 32'(almost_empty_o), 32'(mq.size() <= AE));
            chk("m_ovf", 32'(overflow_o), 32'(m_ovf));
            chk("m_unf", 32'(underflow_o), 32'(m_unf));
            if (mq.size() != 0) chk("m_rd_data", 32'(rd_data_o), 32'(mq[0]));
        end
    end

    // Counts SRAM writes while the bypass-swap stream runs.
    logic byp_phase = 1'b0;
    int   wen_cnt = 0;
    initial forever begin
        @(posedge clk_i);
        if (byp_phase && dut.sram_wen) wen_cnt++;
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                        input logic f, input logic e);
        @(negedge clk_i);
        #1;
        wr_valid_i = v;
        wr_data_i  = d;
        rd_ready_i = r;
        flush_i    = f;
        err_clr_i  = e;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_rd_valid"}, 32'(rd_valid_o), 32'd0);
        chk({nm, "_wr_ready"}, 32'(wr_ready_o), 32'd1);
        chk({nm, "_level"}, 32'(level_o), 32'd0);
        chk({nm, "_af"}, 32'(almost_full_o), 32'd0);
        chk({nm, "_ae"}, 32'(almost_empty_o), 32'd1);
        chk({nm, "_ovf"}, 32'(overflow_o), 32'd0);
        chk({nm, "_unf"}, 32'(underflow_o), 32'd0);
    endtask

    logic [W-1:0] byte_v;
    logic [0:4]   af_tab;

    initial begin
        af_tab = 5'b00011;
        #3 rst_ni = 1'b0;
        #1 chk_reset_vals("rst");
        chk_en = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill 0x11..0x15 with no reads.
        for (int i = 0; i < D; i++) begin
            byte_v = 8'h11 + 8'(i);
            step(1'b1, byte_v, 1'b0, 1'b0, 1'b0);
            chk("fill_level", 32'(level_o), 32'(i + 1));
            chk("fill_head", 32'(rd_data_o), 32'h11);
            chk("fill_af", 32'(almost_full_o), 32'(af_tab[i]));
        end
        chk("full_wr_ready", 32'(wr_ready_o), 32'd0);

        // Drain at one word per cycle.
        for (int i = 0; i < D; i++) begin
            byte_v = 8'h11 + 8'(i);
            chk("drain_head", 32'(rd_data_o), 32'(byte_v));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("drain_level", 32'(level_o), 32'd0);

        // Bypass-swap stream: push and pop every cycle at level 1.
        byp_phase = 1'b1;
        step(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
        chk("byp_first", 32'(rd_data_o), 32'hA0);
        for (int k = 1; k < 16; k++) begin
            byte_v = 8'hA0 + 8'(k);
            step(1'b1, byte_v, 1'b1, 1'b0, 1'b0);
            chk("byp_data", 32'(rd_data_o), 32'(byte_v));
            chk("byp_level", 32'(level_o), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        byp_phase = 1'b0;
        chk("byp_no_sram_write", 32'(wen_cnt), 32'd0);
        chk("byp_empty", 32'(rd_valid_o), 32'd0);

        // Random traffic across the pointer wrap; the model checks each cycle.
        for (int i = 0; i < 23; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        while (level_o != 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Overflow then underflow, both sticky until err_clr_i.
        for (int i = 0; i < D; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_level", 32'(level_o), 32'd5);
        for (int i = 0; i < D; i++) begin
            byte_v = 8'h30 + 8'(i);
            chk("ovf_order", 32'(rd_data_o), 32'(byte_v));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("unf_set", 32'(underflow_o), 32'd1);
        chk("unf_level", 32'(level_o), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        chk("unf_sticky", 32'(underflow_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow_o), 32'd0);
        chk("unf_clr", 32'(underflow_o), 32'd0);

        // Flush at level 3 together with a push.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_level", 32'(level_o), 32'd3);
        step(1'b1, 8'h5F, 1'b0, 1'b1, 1'b0);
        chk("flush_level", 32'(level_o), 32'd0);
        chk("flush_rd_valid", 32'(rd_valid_o), 32'd0);
        step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        chk("post_flush_head", 32'(rd_data_o), 32'h61);

        // Async reset in the middle of a burst with an error flag set.
        for (int i = 0; i < D; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("post_rst_head", 32'(rd_data_o), 32'h99);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/fifo_sram_showahead_lvl.md
Name: fifo_sram_showahead_lvl

Overview:
- Next-generation show-ahead (first-word fall-through) FIFO built on the existing one-read-one-write synchronous SRAM (sram_dualport).
- SRAM read latency is hidden by a prefetch/bypass output register.
- Adds over the previous generation: valid/ready handshakes, arbitrary (non-power-of-two) depth, an occupancy level, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Used as the standard buffering element between streaming stages.

Parameters:
- WIDTH, 8, data word width in bits, >=1.
- DEPTH, 8, number of storage entries, >=2, any integer (non-power-of-two allowed).
- AF_LEVEL, DEPTH-1, almost_full_o asserts when level >= AF_LEVEL, range 1..DEPTH.
- AE_LEVEL, 1, almost_empty_o asserts when level <= AE_LEVEL, range 0..DEPTH-1.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of contents and pointers; has priority over push and pop.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  space available; equals ~full.
- wr_data_i  in  WIDTH  write data.
- rd_valid_o  out  1  head word present on rd_data_o; equals ~empty.
- rd_ready_i  in  1  consumer accepts head word.
- rd_data_o  out  WIDTH  head word, show-ahead.
- level_o  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full_o  out  1  level_o >= AF_LEVEL.
- almost_empty_o  out  1  level_o <= AE_LEVEL.
- overflow_o  out  1  sticky: a write was attempted while full.
- underflow_o  out  1  sticky: a read was attempted while empty.
- err_clr_i  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (rst_ni low, asynchronous, any cycle including mid-transfer):
  - Pointers and level go to 0; bypass-valid and sticky flags clear.
  - Outputs: rd_valid_o=0, wr_ready_o=1, level_o=0, almost_full_o=(AF_LEVEL==0)=0, almost_empty_o=1, overflow_o=0, underflow_o=0.
  - rd_data_o is don't-care while rd_valid_o=0.
  - Deassertion takes effect at the first rising edge after rst_ni goes high.
- Push and pop:
  - push = wr_valid_i & wr_ready_o; pop = rd_valid_o & rd_ready_i.
  - wr_ready_o depends only on state: no combinational path from rd_ready_i.
  - When full, push is rejected even if a pop occurs in the same cycle.
- Pointers:
  - wr_ptr/rd_ptr have width $clog2(DEPTH) and wrap from DEPTH-1 to 0 explicitly; a power-of-two rollover must not be relied on.
  - Full/empty are derived from a level counter: level +1 on push only, -1 on pop only, unchanged on both or neither.
- Show-ahead latency:
  - A word pushed at edge N is visible on rd_data_o with rd_valid_o=1 after edge N (1-cycle write-to-read).
  - After a pop at edge N, the next word is on rd_data_o after edge N, so back-to-back pops run at 1 word/cycle.
- Bypass:
  - The incoming word goes to the output register instead of SRAM when (empty & push) or (level==1 & push & pop).
  - Otherwise a push writes SRAM at wr_ptr.
- Prefetch:
  - SRAM read address = rd_ptr+1 (wrapped).
  - ren = pop & (level >= 2).
  - Output mux selects the bypass register while bypass-valid, else SRAM rdata.
  - sram_dualport holds rdata when ren=0.
  - SRAM read and write never target the same address in the same cycle.
- Ordering: strict FIFO order for all push/pop interleavings.
- flush_i:
  - Next edge: level=0, pointers=0, bypass-valid=0; push/pop in that cycle are discarded.
  - Sticky flags are not affected by flush_i.
- Error flags:
  - overflow_o sets on wr_valid_i & ~wr_ready_o.
  - underflow_o sets on rd_ready_i & ~rd_valid_o.
  - err_clr_i clears both; if a set condition occurs in the same cycle as err_clr_i, set wins.
- almost_full_o, almost_empty_o and level_o are registered-state functions, updated on the same edge as level.

Test Plan:
- WIDTH=8, DEPTH=5: push 0x11..0x15 on consecutive cycles, rd_ready_i=0 -> wr_ready_o=0 after the 5th edge, level_o=5, almost_full_o=1 from level 4, rd_data_o=0x11 from the edge after the first push.
- Full FIFO, rd_ready_i=1 for 5 cycles -> rd_data_o sequence 0x11,0x12,0x13,0x14,0x15 one per cycle, then rd_valid_o=0, level_o=0.
- Empty FIFO, continuous push and pop every cycle of 0xA0..0xAF (bypass-swap path) -> each word appears on rd_data_o 1 cycle after its push, level_o alternates 1/1, no SRAM write.
- Wrap-around: 23 random push/pop cycles at DEPTH=5 -> output equals the scoreboard model, level_o matches the model every cycle.
- Push while full, then pop while empty -> overflow_o=1 and underflow_o=1 stay set; level_o unchanged; err_clr_i pulse clears both the next edge.
- level_o=3, assert flush_i together with push -> next edge level_o=0, rd_valid_o=0; async rst_ni pulse mid-burst -> all outputs return to reset values immediately.
